// File: rtl/keypad_conditioner.sv
// Keypad front end: 2-flop synchronizer, per-key debounce and a lowest-index
// priority encoder with registered press/release strobes.
module keypad_conditioner #(
  parameter int NUM_KEYS        = 15,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int CNT_W           = 14
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                en,
  input  logic [NUM_KEYS-1:0] keypad_i,
  output logic [NUM_KEYS-1:0] keys_stable_o,
  output logic                key_valid_o,
  output logic [3:0]          key_idx_o,
  output logic                key_press_o,
  output logic                key_release_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1_p0;
  logic [NUM_KEYS-1:0] sync2_p1;
  logic [NUM_KEYS-1:0] stable_p2;
  logic [CNT_W-1:0]    cnt_p2 [NUM_KEYS];
  logic                nxt_vld;
  logic [3:0]          nxt_idx;

  // Lowest held key wins; no key held encodes as index 0.
  function automatic logic [3:0] lowest_idx(input logic [NUM_KEYS-1:0] v);
    lowest_idx = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (v[k]) lowest_idx = 4'(k);
    end
  endfunction

  // Stage p0/p1: synchronizer, free-running regardless of enable
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_p0 <= '0;
      sync2_p1 <= '0;
    end else begin
      sync1_p0 <= keypad_i;
      sync2_p1 <= sync1_p0;
    end
  end

  // Stage p2: per-key debounce
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stable_p2 <= '0;
      for (int k = 0; k < NUM_KEYS; k++) cnt_p2[k] <= '0;
    end else if (!en) begin
      stable_p2 <= '0;
      for (int k = 0; k < NUM_KEYS; k++) cnt_p2[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (sync2_p1[k] == stable_p2[k]) begin
          cnt_p2[k] <= '0;
        end else if (cnt_p2[k] == CNT_MAX) begin
          stable_p2[k] <= sync2_p1[k];
          cnt_p2[k]    <= '0;
        end else begin
          cnt_p2[k] <= cnt_p2[k] + CNT_W'(1);
        end
      end
    end
  end

  assign keys_stable_o = stable_p2;

  always_comb begin
    nxt_vld = |stable_p2;
    nxt_idx = lowest_idx(stable_p2);
  end

  // Stage p3: encoder outputs and strobes, compared against their own previous value
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      key_valid_o   <= 1'b0;
      key_idx_o     <= '0;
      key_press_o   <= 1'b0;
      key_release_o <= 1'b0;
    end else if (!en) begin
      key_valid_o   <= 1'b0;
      key_idx_o     <= '0;
      key_press_o   <= 1'b0;
      key_release_o <= 1'b0;
    end else begin
      key_valid_o   <= nxt_vld;
      key_idx_o     <= nxt_idx;
      key_press_o   <= nxt_vld && (!key_valid_o || (nxt_idx != key_idx_o));
      key_release_o <= key_valid_o && !nxt_vld;
    end
  end

endmodule

// File: tb/tb_keypad_conditioner.sv
// Directed table-driven bench for keypad_conditioner with DEBOUNCE_CYCLES=4.
module tb_keypad_conditioner;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        en;
  logic [14:0] keypad_i;
  logic [14:0] keys_stable_o;
  logic        key_valid_o;
  logic [3:0]  key_idx_o;
  logic        key_press_o;
  logic        key_release_o;

  int n_tests = 0;
  int n_fail  = 0;

  keypad_conditioner #(
    .NUM_KEYS(15),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(14)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .en(en),
    .keypad_i(keypad_i),
    .keys_stable_o(keys_stable_o),
    .key_valid_o(key_valid_o),
    .key_idx_o(key_idx_o),
    .key_press_o(key_press_o),
    .key_release_o(key_release_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        rst_n;
    logic        en;
    logic [14:0] keys;
    logic [14:0] stb;
    logic        vld;
    logic [3:0]  idx;
    logic        prs;
    logic        rel;
  } vec_t;

  vec_t tbl[$];

  task automatic hold(input int n, input string nm, input logic rst_n, input logic en_v,
                      input logic [14:0] keys, input logic [14:0] stb, input logic vld,
                      input logic [3:0] idx, input logic prs, input logic rel);
    vec_t v;
    v.nm = nm; v.rst_n = rst_n; v.en = en_v; v.keys = keys;
    v.stb = stb; v.vld = vld; v.idx = idx; v.prs = prs; v.rel = rel;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic check(input string nm, input int step, input logic [14:0] stb,
                       input logic vld, input logic [3:0] idx, input logic prs, input logic rel);
    n_tests++;
    if ({keys_stable_o, key_valid_o, key_idx_o, key_press_o, key_release_o} !==
        {stb, vld, idx, prs, rel}) begin
      n_fail++;
      $display("FAIL %s[%0d]: got stable=%h vld=%b idx=%0d prs=%b rel=%b, want stable=%h vld=%b idx=%0d prs=%b rel=%b",
               nm, step, keys_stable_o, key_valid_o, key_idx_o, key_press_o, key_release_o,
               stb, vld, idx, prs, rel);
    end
  endtask

  // Each entry is applied just after an edge and checked just after the next edge.
  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) begin
      n_rst    = tbl[i].rst_n;
      en       = tbl[i].en;
      keypad_i = tbl[i].keys;
      @(posedge clk);
      #1;
      check(tbl[i].nm, i, tbl[i].stb, tbl[i].vld, tbl[i].idx, tbl[i].prs, tbl[i].rel);
    end
    tbl.delete();
  endtask

  initial begin
    n_rst = 1'b0;
    en = 1'b1;
    keypad_i = 15'h7FFF;
    #1;
    check("reset_t0", 0, 15'h0, 0, 0, 0, 0);

    // Reset with all keys held, then release
    hold(3, "reset_hold", 0, 1, 15'h7FFF, 15'h0, 0, 0, 0, 0);
    hold(5, "rst_rel_pre", 1, 1, 15'h7FFF, 15'h0, 0, 0, 0, 0);
    hold(1, "rst_rel_stb", 1, 1, 15'h7FFF, 15'h7FFF, 0, 0, 0, 0);
    hold(1, "rst_rel_prs", 1, 1, 15'h7FFF, 15'h7FFF, 1, 0, 1, 0);
    hold(1, "rst_rel_one", 1, 1, 15'h7FFF, 15'h7FFF, 1, 0, 0, 0);
    hold(5, "all_up_pre", 1, 1, 15'h0000, 15'h7FFF, 1, 0, 0, 0);
    hold(1, "all_up_stb", 1, 1, 15'h0000, 15'h0000, 1, 0, 0, 0);
    hold(1, "all_up_rel", 1, 1, 15'h0000, 15'h0000, 0, 0, 0, 1);
    hold(1, "all_up_one", 1, 1, 15'h0000, 15'h0000, 0, 0, 0, 0);

    // Clean press of key 2 and its release
    hold(5, "k2_pre", 1, 1, 15'h0004, 15'h0000, 0, 0, 0, 0);
    hold(1, "k2_stb", 1, 1, 15'h0004, 15'h0004, 0, 0, 0, 0);
    hold(1, "k2_prs", 1, 1, 15'h0004, 15'h0004, 1, 2, 1, 0);
    hold(2, "k2_hold", 1, 1, 15'h0004, 15'h0004, 1, 2, 0, 0);
    hold(5, "k2_up_pre", 1, 1, 15'h0000, 15'h0004, 1, 2, 0, 0);
    hold(1, "k2_up_stb", 1, 1, 15'h0000, 15'h0000, 1, 2, 0, 0);
    hold(1, "k2_up_rel", 1, 1, 15'h0000, 15'h0000, 0, 0, 0, 1);
    hold(1, "k2_up_one", 1, 1, 15'h0000, 15'h0000, 0, 0, 0, 0);

    // Bounce on key 4: two cycles high, two low, never long enough
    for (int b = 0; b < 5; b++) begin
      hold(2, "bounce_hi", 1, 1, 15'h0010, 15'h0000, 0, 0, 0, 0);
      hold(2, "bounce_lo", 1, 1, 15'h0000, 15'h0000, 0, 0, 0, 0);
    end
    hold(6, "bounce_tail", 1, 1, 15'h0000, 15'h0000, 0, 0, 0, 0);

    // Keys 3 and 7, then hand over to 7, then release
    hold(5, "k37_pre", 1, 1, 15'h0088, 15'h0000, 0, 0, 0, 0);
    hold(1, "k37_stb", 1, 1, 15'h0088, 15'h0088, 0, 0, 0, 0);
    hold(1, "k37_prs", 1, 1, 15'h0088, 15'h0088, 1, 3, 1, 0);
    hold(1, "k37_hold", 1, 1, 15'h0088, 15'h0088, 1, 3, 0, 0);
    hold(5, "k7_pre", 1, 1, 15'h0080, 15'h0088, 1, 3, 0, 0);
    hold(1, "k7_stb", 1, 1, 15'h0080, 15'h0080, 1, 3, 0, 0);
    hold(1, "k7_handover", 1, 1, 15'h0080, 15'h0080, 1, 7, 1, 0);
    hold(1, "k7_hold", 1, 1, 15'h0080, 15'h0080, 1, 7, 0, 0);
    hold(5, "k7_up_pre", 1, 1, 15'h0000, 15'h0080, 1, 7, 0, 0);
    hold(1, "k7_up_stb", 1, 1, 15'h0000, 15'h0000, 1, 7, 0, 0);
    hold(1, "k7_up_rel", 1, 1, 15'h0000, 15'h0000, 0, 0, 0, 1);
    hold(1, "k7_up_one", 1, 1, 15'h0000, 15'h0000, 0, 0, 0, 0);

    // Enable gating with key 9 held
    hold(5, "k9_pre", 1, 1, 15'h0200, 15'h0000, 0, 0, 0, 0);
    hold(1, "k9_stb", 1, 1, 15'h0200, 15'h0200, 0, 0, 0, 0);
    hold(1, "k9_prs", 1, 1, 15'h0200, 15'h0200, 1, 9, 1, 0);
    hold(2, "k9_hold", 1, 1, 15'h0200, 15'h0200, 1, 9, 0, 0);
    hold(4, "en_low", 1, 0, 15'h0200, 15'h0000, 0, 0, 0, 0);
    hold(3, "en_up_pre", 1, 1, 15'h0200, 15'h0000, 0, 0, 0, 0);
    hold(1, "en_up_stb", 1, 1, 15'h0200, 15'h0200, 0, 0, 0, 0);
    hold(1, "en_up_prs", 1, 1, 15'h0200, 15'h0200, 1, 9, 1, 0);
    hold(1, "en_up_hold", 1, 1, 15'h0200, 15'h0200, 1, 9, 0, 0);
    hold(5, "k9_up_pre", 1, 1, 15'h0000, 15'h0200, 1, 9, 0, 0);
    hold(1, "k9_up_stb", 1, 1, 15'h0000, 15'h0000, 1, 9, 0, 0);
    hold(1, "k9_up_rel", 1, 1, 15'h0000, 15'h0000, 0, 0, 0, 1);
    hold(1, "k9_up_one", 1, 1, 15'h0000, 15'h0000, 0, 0, 0, 0);

    // Key 5 stable, then key 2 added and debounced up to count 2
    hold(5, "k5_pre", 1, 1, 15'h0020, 15'h0000, 0, 0, 0, 0);
    hold(1, "k5_stb", 1, 1, 15'h0020, 15'h0020, 0, 0, 0, 0);
    hold(1, "k5_prs", 1, 1, 15'h0020, 15'h0020, 1, 5, 1, 0);
    hold(1, "k5_hold", 1, 1, 15'h0020, 15'h0020, 1, 5, 0, 0);
    hold(4, "k25_cnt", 1, 1, 15'h0024, 15'h0020, 1, 5, 0, 0);
    run_table();

    // Asynchronous reset mid-cycle while key 2 is at count 2
    #2;
    n_rst = 1'b0;
    #1;
    check("async_rst_now", 0, 15'h0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("async_rst_edge", 0, 15'h0, 0, 0, 0, 0);

    // Full latency after reset release
    hold(5, "k25_post_pre", 1, 1, 15'h0024, 15'h0000, 0, 0, 0, 0);
    hold(1, "k25_post_stb", 1, 1, 15'h0024, 15'h0024, 0, 0, 0, 0);
    hold(1, "k25_post_prs", 1, 1, 15'h0024, 15'h0024, 1, 2, 1, 0);
    hold(1, "k25_post_hold", 1, 1, 15'h0024, 15'h0024, 1, 2, 0, 0);
    run_table();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
